// File: rtl/column_multisrc_l1route_pipe.sv
// Column-wise first-level message router: per stride unit, pick one message source and
// left-rotate every bit-plane by that stride's shift factor, over two valid/ready register stages.
module column_multisrc_l1route_pipe #(
   parameter int QUAN_SIZE        = 4,
   parameter int STRIDE_UNIT_SIZE = 15,
   parameter int STRIDE_WIDTH     = 3,
   parameter int SRC_NUM          = 2,
   parameter int SHIFT_W          = $clog2(STRIDE_UNIT_SIZE),
   parameter int SEL_W            = $clog2(SRC_NUM),
   parameter int PLANE            = STRIDE_WIDTH*QUAN_SIZE*STRIDE_UNIT_SIZE
)(
   input  logic                            sys_clk,
   input  logic                            rstn,
   input  logic [SRC_NUM*PLANE-1:0]        in_msg_i,
   input  logic [SEL_W-1:0]                src_sel_i,
   input  logic [STRIDE_WIDTH*SHIFT_W-1:0] shift_i,
   input  logic [STRIDE_WIDTH-1:0]         stride_en_i,
   input  logic                            in_valid_i,
   output logic                            in_ready_o,
   output logic [PLANE-1:0]                out_msg_o,
   output logic                            out_valid_o,
   input  logic                            out_ready_i,
   output logic                            cfg_err_o
);

   localparam int Z = STRIDE_UNIT_SIZE;
   localparam logic [SHIFT_W:0] Z_LIM   = (SHIFT_W+1)'(STRIDE_UNIT_SIZE);
   localparam logic [SEL_W:0]   SRC_LIM = (SEL_W+1)'(SRC_NUM);

   logic                            s1_valid;
   logic [PLANE-1:0]                s1_data;
   logic [STRIDE_WIDTH*SHIFT_W-1:0] s1_shift;
   logic [STRIDE_WIDTH-1:0]         s1_zero;
   logic                            s2_valid;
   logic [PLANE-1:0]                s2_data;
   logic                            cfg_err;

   logic                    s1_adv;
   logic                    s2_adv;
   logic [PLANE-1:0]        sel_data;
   logic                    src_bad;
   logic [STRIDE_WIDTH-1:0] shift_bad;
   logic [PLANE-1:0]        rot_data;

   // Rotating the doubled word right by s gives out[l] = w[(l + s) mod Z] for any s < Z.
   function automatic logic [Z-1:0] rotl(input logic [Z-1:0] w, input logic [SHIFT_W-1:0] s);
      logic [2*Z-1:0] d;
      d = {w, w} >> s;
      return d[Z-1:0];
   endfunction

   assign s2_adv      = !s2_valid || out_ready_i;
   assign s1_adv      = !s1_valid || s2_adv;
   assign in_ready_o  = s1_adv;
   assign out_msg_o   = s2_data;
   assign out_valid_o = s2_valid;
   assign cfg_err_o   = cfg_err;

   always_comb begin
      sel_data = '0;
      for (int s = 0; s < SRC_NUM; s++) begin
         if (src_sel_i == SEL_W'(s)) begin
            sel_data = in_msg_i[s*PLANE +: PLANE];
         end
      end
      src_bad = ({1'b0, src_sel_i} >= SRC_LIM);
      for (int u = 0; u < STRIDE_WIDTH; u++) begin
         shift_bad[u] = ({1'b0, shift_i[u*SHIFT_W +: SHIFT_W]} >= Z_LIM);
      end
   end

   always_comb begin
      rot_data = '0;
      for (int u = 0; u < STRIDE_WIDTH; u++) begin
         for (int q = 0; q < QUAN_SIZE; q++) begin
            if (!s1_zero[u]) begin
               rot_data[(u*QUAN_SIZE+q)*Z +: Z] =
                  rotl(s1_data[(u*QUAN_SIZE+q)*Z +: Z], s1_shift[u*SHIFT_W +: SHIFT_W]);
            end
         end
      end
   end

   // Stage 2 drains or refills whenever it is empty or downstream takes its beat; stage 1
   // follows whenever it can hand its beat on, so both stages can move in the same cycle.
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_shift <= '0;
         s1_zero  <= '0;
         s2_valid <= 1'b0;
         s2_data  <= '0;
         cfg_err  <= 1'b0;
      end else begin
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_data <= rot_data;
            end
         end
         if (s1_adv) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
               s1_data  <= src_bad ? '0 : sel_data;
               s1_shift <= shift_i;
               s1_zero  <= shift_bad | ~stride_en_i;
               if (src_bad || (|shift_bad)) begin
                  cfg_err <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_column_multisrc_l1route_pipe.sv
// Scoreboard bench for column_multisrc_l1route_pipe: expected beats are queued on accept
// from an index-level routing model and compared when the DUT hands a beat downstream.
module tb_column_multisrc_l1route_pipe;

   localparam int Q     = 4;
   localparam int Z     = 15;
   localparam int SW    = 3;
   localparam int SN    = 2;
   localparam int SHW   = 4;
   localparam int SELW  = 1;
   localparam int PLANE = SW*Q*Z;

   logic                 sys_clk = 1'b0;
   logic                 rstn = 1'b0;
   logic [SN*PLANE-1:0]  in_msg_i = '0;
   logic [SELW-1:0]      src_sel_i = '0;
   logic [SW*SHW-1:0]    shift_i = '0;
   logic [SW-1:0]        stride_en_i = '0;
   logic                 in_valid_i = 1'b0;
   logic                 in_ready_o;
   logic [PLANE-1:0]     out_msg_o;
   logic                 out_valid_o;
   logic                 out_ready_i = 1'b0;
   logic                 cfg_err_o;

   int                   n_checks = 0;
   int                   n_fail = 0;
   int                   accepted = 0;
   logic [PLANE-1:0]     sb[$];
   logic                 err_model = 1'b0;
   logic                 hold_pending = 1'b0;
   logic [PLANE-1:0]     held = '0;

   always #5 sys_clk = ~sys_clk;

   column_multisrc_l1route_pipe #(
      .QUAN_SIZE(Q), .STRIDE_UNIT_SIZE(Z), .STRIDE_WIDTH(SW), .SRC_NUM(SN)
   ) dut (
      .sys_clk(sys_clk), .rstn(rstn), .in_msg_i(in_msg_i), .src_sel_i(src_sel_i),
      .shift_i(shift_i), .stride_en_i(stride_en_i), .in_valid_i(in_valid_i),
      .in_ready_o(in_ready_o), .out_msg_o(out_msg_o), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .cfg_err_o(cfg_err_o)
   );

   task automatic chk(input string tag, input logic [PLANE-1:0] obs, input logic [PLANE-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [PLANE-1:0] ref_route(input logic [SN*PLANE-1:0] m, input int sel,
                                                  input logic [SW*SHW-1:0] sh, input logic [SW-1:0] en);
      logic [PLANE-1:0] r;
      int s;
      r = '0;
      for (int u = 0; u < SW; u++) begin
         s = int'(sh[u*SHW +: SHW]);
         if (en[u] && s < Z && sel < SN) begin
            for (int q = 0; q < Q; q++) begin
               for (int l = 0; l < Z; l++) begin
                  r[(u*Q+q)*Z+l] = m[((sel*SW+u)*Q+q)*Z + (l+s)%Z];
               end
            end
         end
      end
      return r;
   endfunction

   function automatic logic [SN*PLANE-1:0] rand_msg();
      logic [SN*PLANE-1:0] r;
      for (int i = 0; i < SN*PLANE; i++) r[i] = 1'($urandom_range(0, 1));
      return r;
   endfunction

   function automatic logic [SW*SHW-1:0] rand_shift();
      logic [SW*SHW-1:0] r;
      for (int u = 0; u < SW; u++) r[u*SHW +: SHW] = SHW'($urandom_range(0, Z-1));
      return r;
   endfunction

   // Evaluated at the falling edge once inputs have settled; outputs are compared here and
   // the beat about to be accepted at the next rising edge is modelled and queued.
   task automatic checkOutput();
      logic [PLANE-1:0] exp;
      logic bad;
      if (hold_pending) begin
         chk1("hold_valid", out_valid_o, 1'b1);
         chk("hold_data", out_msg_o, held);
      end
      chk1("in_ready", in_ready_o, !(sb.size() == 2 && !out_ready_i));
      if (out_valid_o === 1'b1) begin
         if (sb.size() == 0) begin
            chk1("spurious_out", out_valid_o, 1'b0);
         end else if (out_ready_i) begin
            exp = sb.pop_front();
            chk("out_msg", out_msg_o, exp);
            chk1("cfg_err", cfg_err_o, err_model);
         end
      end
      hold_pending = (out_valid_o === 1'b1) && !out_ready_i;
      held = out_msg_o;
      if (in_valid_i && in_ready_o === 1'b1) begin
         sb.push_back(ref_route(in_msg_i, int'(src_sel_i), shift_i, stride_en_i));
         bad = (int'(src_sel_i) >= SN);
         for (int u = 0; u < SW; u++) if (int'(shift_i[u*SHW +: SHW]) >= Z) bad = 1'b1;
         if (bad) err_model = 1'b1;
         accepted++;
      end
   endtask

   task automatic applyStimulus(input logic [SN*PLANE-1:0] msg, input logic [SELW-1:0] sel,
                                input logic [SW*SHW-1:0] sh, input logic [SW-1:0] en,
                                input logic vld, input logic rdy);
      in_msg_i    = msg;
      src_sel_i   = sel;
      shift_i     = sh;
      stride_en_i = en;
      in_valid_i  = vld;
      out_ready_i = rdy;
      #1;
      if (rstn) checkOutput();
      @(posedge sys_clk);
      @(negedge sys_clk);
   endtask

   task automatic idle(input logic rdy);
      applyStimulus(in_msg_i, src_sel_i, shift_i, stride_en_i, 1'b0, rdy);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1'b1);
      chk("drain_left", PLANE'(sb.size()), '0);
   endtask

   task automatic resetPhase(input int cycles);
      rstn = 1'b0;
      for (int i = 0; i < cycles; i++) applyStimulus(rand_msg(), 1'b1, rand_shift(), 3'b111, 1'b1, 1'b0);
      chk1("rst_valid", out_valid_o, 1'b0);
      chk("rst_msg", out_msg_o, '0);
      chk1("rst_err", cfg_err_o, 1'b0);
      sb.delete();
      err_model = 1'b0;
      hold_pending = 1'b0;
      rstn = 1'b1;
   endtask

   initial begin
      logic [SN*PLANE-1:0] msg;
      int base;
      int c;

      @(negedge sys_clk);
      resetPhase(3);
      chk1("rst_ready", in_ready_o, 1'b1);

      // Single rotation with two-stage latency
      msg = rand_msg();
      msg[PLANE +: Z] = 15'h0001;
      applyStimulus(msg, 1'b1, {4'd5, 4'd7, 4'd3}, 3'b111, 1'b1, 1'b1);
      chk1("lat1_valid", out_valid_o, 1'b0);
      idle(1'b1);
      chk1("lat2_valid", out_valid_o, 1'b1);
      chk("t2_s0p0", PLANE'(out_msg_o[Z-1:0]), PLANE'(15'h1000));
      drain();

      // Maximum legal shift, then zero shift pass-through
      msg = rand_msg();
      msg[0 +: Z] = 15'h4000;
      applyStimulus(msg, 1'b0, {4'd14, 4'd14, 4'd14}, 3'b111, 1'b1, 1'b1);
      drain();
      msg = rand_msg();
      applyStimulus(msg, 1'b1, '0, 3'b111, 1'b1, 1'b1);
      idle(1'b1);
      chk("t3_pass", out_msg_o, msg[PLANE +: PLANE]);
      drain();

      // Back-pressure with out_ready pattern 1,0,0,1
      base = accepted;
      c = 0;
      while (accepted - base < 8 && c < 200) begin
         applyStimulus(rand_msg(), SELW'($urandom_range(0, SN-1)), rand_shift(),
                       SW'($urandom_range(0, 7)), 1'b1, (c % 4 == 0) || (c % 4 == 3));
         c++;
      end
      chk("t4_beats", PLANE'(accepted - base), PLANE'(8));
      drain();

      // Illegal shift on stride 1; error is sticky across a later legal beat
      applyStimulus(rand_msg(), 1'b0, {4'd2, 4'd15, 4'd6}, 3'b111, 1'b1, 1'b1);
      drain();
      chk1("t5_err", cfg_err_o, 1'b1);
      applyStimulus(rand_msg(), 1'b1, {4'd1, 4'd2, 4'd3}, 3'b111, 1'b1, 1'b1);
      drain();
      chk1("t5_sticky", cfg_err_o, 1'b1);

      // Reset in the middle of a stalled stream clears everything
      for (int i = 0; i < 3; i++) applyStimulus(rand_msg(), 1'b0, rand_shift(), 3'b111, 1'b1, 1'b0);
      resetPhase(3);
      idle(1'b1);
      idle(1'b1);
      chk1("t1_no_stale", out_valid_o, 1'b0);

      // Stride mask is not an error
      applyStimulus(rand_msg(), 1'b1, {4'd4, 4'd9, 4'd11}, 3'b101, 1'b1, 1'b1);
      drain();
      chk1("t6_err", cfg_err_o, 1'b0);

      // Random sweep with random valid/ready
      base = accepted;
      c = 0;
      while (accepted - base < 10000 && c < 40000) begin
         applyStimulus(rand_msg(), SELW'($urandom_range(0, SN-1)), rand_shift(),
                       SW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
         c++;
      end
      chk("sweep_beats", PLANE'(accepted - base), PLANE'(10000));
      drain();
      chk1("sweep_err", cfg_err_o, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
